// File: rtl/monitor_history_pkg.sv
// Shared constants for the instruction history monitor: record layout and defaults.
// Byte offsets describe where each CPU field sits inside the 24-byte record.
package monitor_history_pkg;

  localparam int HISTORY_DEPTH = 1024;
  localparam int REC_LO_BYTES  = 16;
  localparam int REC_HI_BYTES  = 8;
  localparam int REC_LO_W      = REC_LO_BYTES * 8;
  localparam int REC_HI_W      = REC_HI_BYTES * 8;
  localparam int REC_W         = REC_LO_W + REC_HI_W;

  // Record field byte offsets (bytes 13-15 are spare)
  localparam int OFS_PC      = 0;
  localparam int OFS_OPCODE  = 2;
  localparam int OFS_OPERAND = 3;
  localparam int OFS_A       = 5;
  localparam int OFS_X       = 6;
  localparam int OFS_Y       = 7;
  localparam int OFS_Z       = 8;
  localparam int OFS_B       = 9;
  localparam int OFS_FLAGS   = 10;
  localparam int OFS_SP      = 11;
  localparam int OFS_CYCLE   = 16;
  localparam int OFS_BUS     = 20;

  function automatic logic [7:0] pick_byte(input logic [REC_LO_W-1:0] data,
                                           input logic [3:0] sel);
    return data[{sel, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/monitor_history_ram.sv
// Simple dual-port history store: one write port, one registered read port.
// Reads return the previous contents when the same address is written that cycle.
module monitor_history_ram
  import monitor_history_pkg::*;
#(
  parameter int DEPTH = HISTORY_DEPTH,
  parameter int PW    = 10
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PW-1:0]    wr_addr,
  input  logic [REC_W-1:0] wr_data,
  input  logic [PW-1:0]    rd_addr,
  output logic [REC_W-1:0] rd_data
);

  logic [REC_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/monitor_history.sv
// Circular history of retired-instruction records with a newest-relative read index
// and a byte-wide view for the monitor CPU bus.
module monitor_history
  import monitor_history_pkg::*;
#(
  parameter int DEPTH = HISTORY_DEPTH,
  parameter int PW    = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                capture,
  input  logic [REC_LO_W-1:0] capture_lo,
  input  logic [REC_HI_W-1:0] capture_hi,
  input  logic                freeze,
  input  logic                index_load,
  input  logic [PW-1:0]       index_value,
  input  logic                index_inc,
  input  logic [15:0]         cpu_address,
  output logic [7:0]          history_lo,
  output logic [7:0]          history_hi,
  output logic [PW:0]         entry_count,
  output logic                full
);

  localparam logic [PW:0]   COUNT_MAX = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] INDEX_MAX = PW'(DEPTH - 1);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_index;
  logic [PW-1:0]    rd_addr;
  logic             wr_en;
  logic [REC_W-1:0] rd_data;
  logic [3:0]       sel_q;
  logic             valid_q;
  logic             unused_addr;

  // A capture coinciding with reset must not touch the RAM or the pointers.
  assign wr_en       = capture && !freeze && reset_n;
  assign rd_addr     = wr_ptr - PW'(1) - rd_index;
  assign unused_addr = ^cpu_address[15:4];

  monitor_history_ram #(.DEPTH(DEPTH), .PW(PW)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data ({capture_hi, capture_lo}),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_index    <= '0;
      entry_count <= '0;
      full        <= 1'b0;
      sel_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (entry_count != COUNT_MAX) entry_count <= entry_count + (PW+1)'(1);
        if (entry_count >= COUNT_MAX - (PW+1)'(1)) full <= 1'b1;
      end
      if (index_load)
        rd_index <= index_value;
      else if (index_inc && rd_index != INDEX_MAX)
        rd_index <= rd_index + PW'(1);
      // Select and validity travel alongside the RAM read so the byte mux lines up.
      sel_q   <= cpu_address[3:0];
      valid_q <= {1'b0, rd_index} < entry_count;
    end
  end

  assign history_lo = valid_q ? pick_byte(rd_data[REC_LO_W-1:0], sel_q) : 8'h00;
  assign history_hi = valid_q ? pick_byte({{(REC_LO_W-REC_HI_W){1'b0}}, rd_data[REC_W-1:REC_LO_W]},
                                          {1'b0, sel_q[2:0]}) : 8'h00;

endmodule
